// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Bit timing comes from the enable_clk baud tick. A
// one-entry holding buffer lets frames go out back-to-back.
module uart_tx #(
  parameter int PARITY    = 0,  // 0 none, 1 even, 2 odd
  parameter int STOP_BITS = 1   // 1 or 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_clk,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam logic STOP_LAST = (STOP_BITS == 2);

  state_t     state, state_n;
  logic [7:0] buf_data;
  logic       buf_full;
  logic       load;
  logic [7:0] sh, sh_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       stop_cnt, stop_cnt_n;
  logic       par_bit, par_n;
  logic       tx_n, done_n;

  function automatic logic parity_of(input logic [7:0] b);
    return (PARITY == 2) ? ~(^b) : (^b);
  endfunction

  assign tx_ready = !rst && !buf_full;
  assign busy     = (state != IDLE);

  // Holding buffer: accept on handshake, release when the shifter loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (valid_in && tx_ready) begin
      buf_full <= 1'b1;
      buf_data <= data_in;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  // FSM and shifter register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      sh       <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      state    <= state_n;
      tx       <= tx_n;
      tx_done  <= done_n;
      sh       <= sh_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      par_bit  <= par_n;
    end
  end

  // Next-state and next-line logic; only ticks advance the frame.
  always_comb begin
    state_n    = state;
    sh_n       = sh;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    par_n      = par_bit;
    tx_n       = tx;
    done_n     = 1'b0;
    load       = 1'b0;
    if (enable_clk) begin
      case (state)
        IDLE: begin
          tx_n = 1'b1;
          load = buf_full;
        end
        START: begin
          tx_n      = sh[0];
          bit_cnt_n = '0;
          state_n   = DATA;
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
            stop_cnt_n = 1'b0;
            if (PARITY != 0) begin
              tx_n    = par_bit;
              state_n = PAR;
            end else begin
              tx_n    = 1'b1;
              state_n = STOP;
            end
          end else begin
            sh_n      = {1'b0, sh[7:1]};
            tx_n      = sh[1];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        PAR: begin
          tx_n       = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = STOP;
        end
        STOP: begin
          if (stop_cnt == STOP_LAST) begin
            done_n = 1'b1;
            if (buf_full) begin
              load = 1'b1;
            end else begin
              tx_n    = 1'b1;
              state_n = IDLE;
            end
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
        default: begin
          tx_n    = 1'b1;
          state_n = IDLE;
        end
      endcase
      // Shared load path for both IDLE start and back-to-back restart.
      if (load) begin
        sh_n    = buf_data;
        par_n   = parity_of(buf_data);
        tx_n    = 1'b0;
        state_n = START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: four instances cover
// no parity, even, odd and two stop bits.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_clk = 1'b0;
  logic [7:0] din [4];
  logic [3:0] valid = '0;
  logic [3:0] rdy, txl, bsy, dn;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int          div    = 0;

  uart_tx #(.PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .rst(rst), .enable_clk(enable_clk),
    .data_in(din[0]), .valid_in(valid[0]), .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]), .tx_done(dn[0]));
  uart_tx #(.PARITY(1), .STOP_BITS(1)) u1 (.clk(clk), .rst(rst), .enable_clk(enable_clk),
    .data_in(din[1]), .valid_in(valid[1]), .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]), .tx_done(dn[1]));
  uart_tx #(.PARITY(2), .STOP_BITS(1)) u2 (.clk(clk), .rst(rst), .enable_clk(enable_clk),
    .data_in(din[2]), .valid_in(valid[2]), .tx_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]), .tx_done(dn[2]));
  uart_tx #(.PARITY(0), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .enable_clk(enable_clk),
    .data_in(din[3]), .valid_in(valid[3]), .tx_ready(rdy[3]), .tx(txl[3]), .busy(bsy[3]), .tx_done(dn[3]));

  always #5 clk = ~clk;

  // Baud tick: one clk cycle high out of every 16.
  always @(negedge clk) begin
    if (div == 15) begin
      div = 0;
      enable_clk = 1'b1;
    end else begin
      div = div + 1;
      enable_clk = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!enable_clk && n < 64);
    #1;
  endtask

  task automatic send(input int w, input logic [7:0] v);
    int n = 0;
    @(negedge clk);
    din[w]   = v;
    valid[w] = 1'b1;
    while (!rdy[w] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++;
      $error("FAIL send_timeout: unit %0d got ready=0 expected ready=1", w);
    end
    @(negedge clk);
    valid[w] = 1'b0;
  endtask

  task automatic capture(input int w, input int n,
                         output logic [31:0] t, output logic [31:0] b, output logic [31:0] d);
    t = '0;
    b = '0;
    d = '0;
    for (int i = 0; i < n; i++) begin
      wait_tick();
      t[i] = txl[w];
      b[i] = bsy[w];
      d[i] = dn[w];
    end
  endtask

  logic [31:0] t0, b0, d0, t1, b1, d1;

  initial begin
    for (int i = 0; i < 4; i++) din[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {28'd0, rdy}, 32'h0);
    check("rst_tx", {28'd0, txl}, 32'hF);
    check("rst_busy", {28'd0, bsy}, 32'h0);
    check("rst_done", {28'd0, dn}, 32'h0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {28'd0, rdy}, 32'hF);

    // Single byte 0xA5
    send(0, 8'hA5);
    capture(0, 11, t0, b0, d0);
    check("a5_tx", t0, 32'h74A);
    check("a5_busy", b0, 32'h3FF);
    check("a5_done", d0, 32'h400);

    // Back-to-back 0x00, 0xFF
    send(0, 8'h00);
    fork
      send(0, 8'hFF);
      capture(0, 21, t0, b0, d0);
    join
    check("b2b_tx", t0, 32'h1FFA00);
    check("b2b_busy", b0, 32'hFFFFF);
    check("b2b_done", d0, 32'h100400);

    // Even and odd parity, 0x07
    fork
      begin send(1, 8'h07); capture(1, 12, t0, b0, d0); end
      begin send(2, 8'h07); capture(2, 12, t1, b1, d1); end
    join
    check("even_tx", t0, 32'hE0E);
    check("even_busy", b0, 32'h7FF);
    check("even_done", d0, 32'h800);
    check("odd_tx", t1, 32'hC0E);
    check("odd_busy", b1, 32'h7FF);
    check("odd_done", d1, 32'h800);

    // Two stop bits, 0x3C followed by 0x81
    send(3, 8'h3C);
    fork
      send(3, 8'h81);
      capture(3, 12, t0, b0, d0);
    join
    check("stop2_tx", t0, 32'h678);
    check("stop2_busy", b0, 32'hFFF);
    check("stop2_done", d0, 32'h800);
    repeat (12) wait_tick();
    check("stop2_idle", {31'd0, bsy[3]}, 32'h0);

    // Handshake stall with three bytes
    send(0, 8'h11);
    fork
      begin send(0, 8'h22); send(0, 8'h33); end
      capture(0, 31, t0, b0, d0);
      begin
        repeat (3) wait_tick();
        check("stall_ready", {31'd0, rdy[0]}, 32'h0);
        check("stall_valid", {31'd0, valid[0]}, 32'h1);
      end
    join
    check("stall_tx", t0, 32'h66691222);
    check("stall_done", d0, 32'h40100400);

    // Reset during data bit 4 with a byte buffered
    send(0, 8'h99);
    wait_tick();
    send(0, 8'h44);
    check("buffered_ready", {31'd0, rdy[0]}, 32'h0);
    repeat (5) wait_tick();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_tx", {31'd0, txl[0]}, 32'h1);
    check("midrst_busy", {31'd0, bsy[0]}, 32'h0);
    check("midrst_ready", {31'd0, rdy[0]}, 32'h1);
    capture(0, 12, t0, b0, d0);
    check("midrst_quiet_tx", t0, 32'hFFF);
    check("midrst_quiet_busy", b0, 32'h0);

    // Fresh byte after reset
    send(0, 8'h55);
    capture(0, 11, t0, b0, d0);
    check("post_tx", t0, 32'h6AA);
    check("post_busy", b0, 32'h3FF);
    check("post_done", d0, 32'h400);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
